// File: rtl/ofdm_tx_framer.sv
// ofdm_tx_framer
// Builds OFDM transmit frames from 64-sample time-domain symbols. Each frame
// is an optional short-training preamble followed by num_symbols symbols,
// each preceded by a cyclic prefix copied from the symbol tail.
//
// Optional feature macro: OFDM_TX_FRAMER_PREAMBLE_EN
//   defined   : 160-sample preamble from 16 programmable pattern registers
//   undefined : no preamble, o_sof marks CP sample 0 of the first symbol
//
// Ports
//   clk, reset_n             clock, asynchronous active-low reset
//   num_symbols(_valid)      symbols-per-frame register load (clamped)
//   pre_wr_stb/addr/data     preamble pattern register write
//   i_tdata/tvalid/tready    input symbol stream (i_tlast ignored)
//   o_tdata/tvalid/tready    output frame stream, o_tlast on last beat
//   o_sof, o_eof             frame start / end markers, beat-qualified
module ofdm_tx_framer #(
    parameter int SYMBOL_LEN        = 64,
    parameter int CYCLIC_PREFIX_LEN = 16,
    parameter int PREAMBLE_REPS     = 10,
    parameter int MAX_NUM_SYMBOLS   = 10,
    localparam int NW               = $clog2(MAX_NUM_SYMBOLS + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [NW-1:0] num_symbols,
    input  logic          num_symbols_valid,
    input  logic          pre_wr_stb,
    input  logic [3:0]    pre_wr_addr,
    input  logic [31:0]   pre_wr_data,
    input  logic [31:0]   i_tdata,
    input  logic          i_tvalid,
    output logic          i_tready,
    input  logic          i_tlast,
    output logic [31:0]   o_tdata,
    output logic          o_tvalid,
    input  logic          o_tready,
    output logic          o_tlast,
    output logic          o_sof,
    output logic          o_eof
);
    localparam int AW      = $clog2(SYMBOL_LEN);
    localparam int PRE_LEN = 16 * PREAMBLE_REPS;
    localparam int IDX_W   = $clog2((PRE_LEN > SYMBOL_LEN ? PRE_LEN : SYMBOL_LEN) + 1);

`ifdef OFDM_TX_FRAMER_PREAMBLE_EN
    typedef enum logic [1:0] {IDLE, PREAMBLE, CP, BODY} state_t;
`else
    typedef enum logic [1:0] {IDLE, CP, BODY} state_t;
`endif

    logic [NW-1:0]    count_reg;
    logic [31:0]      mem [2*SYMBOL_LEN];
    logic [31:0]      ram_q_reg;
    logic             wr_bank_reg;
    logic [AW-1:0]    wr_ptr_reg;
    logic [1:0]       full_reg, full_next;
    state_t           state_reg, state_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic [NW-1:0]    frames_reg, frames_next;
    logic             rd_bank_reg, rd_bank_next;
    logic             hold_reg, hold_next;
    logic             issue, issue_pre, issue_sof, issue_last, clr_full;
    logic [AW:0]      rd_addr;
    logic [AW-1:0]    cp_off;
    logic [3:0]       pat_sel;
    logic             in_accept, set_full;
    logic             s1_valid_reg, s1_sof_reg, s1_last_reg;
    logic [31:0]      s1_data;
    logic             out_valid_reg, out_sof_reg, out_last_reg;
    logic [31:0]      out_data_reg;
    logic             out_ready, s1_ready;
    logic             unused_inputs;

    assign i_tready  = !full_reg[wr_bank_reg] && (count_reg != '0);
    assign in_accept = i_tvalid && i_tready;
    assign set_full  = in_accept && (wr_ptr_reg == AW'(SYMBOL_LEN - 1));

    // Count register: clamp oversize requests
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= NW'(1);
        end else if (num_symbols_valid) begin
            count_reg <= (num_symbols > NW'(MAX_NUM_SYMBOLS)) ? NW'(MAX_NUM_SYMBOLS) : num_symbols;
        end
    end

    // Input side: sequential fill of the write bank, then hand it over
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_bank_reg <= 1'b0;
            wr_ptr_reg  <= '0;
        end else if (in_accept) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (set_full) wr_bank_reg <= ~wr_bank_reg;
        end
    end

    // Set and clear always target different banks, so both are honoured
    for (genvar gi = 0; gi < 2; gi++) begin : g_full
        assign full_next[gi] = (set_full && wr_bank_reg == 1'(gi)) ? 1'b1 :
                               (clr_full && rd_bank_reg == 1'(gi)) ? 1'b0 : full_reg[gi];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) full_reg <= '0;
        else          full_reg <= full_next;
    end

    // Bank RAM with registered, enabled read. Reset only empties the banks
    // via the full flags; stale contents are never read back.
    always_ff @(posedge clk) begin
        if (in_accept) mem[{wr_bank_reg, wr_ptr_reg}] <= i_tdata;
        if (issue && !issue_pre) ram_q_reg <= mem[rd_addr];
    end

`ifdef OFDM_TX_FRAMER_PREAMBLE_EN
    logic [31:0] pattern_reg [16];
    logic [31:0] pat_q_reg;
    logic        s1_pre_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 16; k++) pattern_reg[k] <= '0;
            pat_q_reg  <= '0;
            s1_pre_reg <= 1'b0;
        end else begin
            if (pre_wr_stb) pattern_reg[pre_wr_addr] <= pre_wr_data;
            if (issue) begin
                s1_pre_reg <= issue_pre;
                if (issue_pre) pat_q_reg <= pattern_reg[pat_sel];
            end
        end
    end

    assign s1_data       = s1_pre_reg ? pat_q_reg : ram_q_reg;
    assign unused_inputs = i_tlast;
`else
    assign s1_data       = ram_q_reg;
    assign unused_inputs = ^{i_tlast, pre_wr_stb, pre_wr_addr, pre_wr_data, pat_sel};
`endif

    // Two-stage output pipe: s1 holds the RAM read result and doubles as the
    // skid slot, the output register drives the ports.
    assign out_ready = !out_valid_reg || o_tready;
    assign s1_ready  = !s1_valid_reg || out_ready;
    assign cp_off    = AW'(SYMBOL_LEN - CYCLIC_PREFIX_LEN) + idx_reg[AW-1:0];
    assign pat_sel   = idx_reg[3:0];

    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        frames_next  = frames_reg;
        rd_bank_next = rd_bank_reg;
        hold_next    = 1'b0;
        issue        = 1'b0;
        issue_pre    = 1'b0;
        issue_sof    = 1'b0;
        issue_last   = 1'b0;
        clr_full     = 1'b0;
        rd_addr      = {rd_bank_reg, idx_reg[AW-1:0]};
        case (state_reg)
            IDLE: begin
                // hold_reg enforces one idle cycle between frames; the first
                // beat is issued from IDLE to keep start latency at 2 cycles
                if (!hold_reg && full_reg[rd_bank_reg] && count_reg != '0 && s1_ready) begin
                    issue       = 1'b1;
                    issue_sof   = 1'b1;
                    frames_next = count_reg;
                    idx_next    = IDX_W'(1);
`ifdef OFDM_TX_FRAMER_PREAMBLE_EN
                    issue_pre   = 1'b1;
                    state_next  = PREAMBLE;
`else
                    rd_addr     = {rd_bank_reg, AW'(SYMBOL_LEN - CYCLIC_PREFIX_LEN)};
                    state_next  = CP;
`endif
                end
            end
`ifdef OFDM_TX_FRAMER_PREAMBLE_EN
            PREAMBLE: begin
                if (s1_ready) begin
                    issue     = 1'b1;
                    issue_pre = 1'b1;
                    if (idx_reg == IDX_W'(PRE_LEN - 1)) begin
                        state_next = CP;
                        idx_next   = '0;
                    end else begin
                        idx_next = idx_reg + IDX_W'(1);
                    end
                end
            end
`endif
            CP: begin
                // waits here on underrun; once started the bank stays full
                if (s1_ready && full_reg[rd_bank_reg]) begin
                    issue   = 1'b1;
                    rd_addr = {rd_bank_reg, cp_off};
                    if (idx_reg == IDX_W'(CYCLIC_PREFIX_LEN - 1)) begin
                        state_next = BODY;
                        idx_next   = '0;
                    end else begin
                        idx_next = idx_reg + IDX_W'(1);
                    end
                end
            end
            BODY: begin
                if (s1_ready) begin
                    issue = 1'b1;
                    if (idx_reg == IDX_W'(SYMBOL_LEN - 1)) begin
                        clr_full     = 1'b1;
                        rd_bank_next = ~rd_bank_reg;
                        frames_next  = frames_reg - NW'(1);
                        idx_next     = '0;
                        if (frames_reg == NW'(1)) begin
                            issue_last = 1'b1;
                            hold_next  = 1'b1;
                            state_next = IDLE;
                        end else begin
                            state_next = CP;
                        end
                    end else begin
                        idx_next = idx_reg + IDX_W'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            idx_reg     <= '0;
            frames_reg  <= '0;
            rd_bank_reg <= 1'b0;
            hold_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            frames_reg  <= frames_next;
            rd_bank_reg <= rd_bank_next;
            hold_reg    <= hold_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_reg  <= 1'b0;
            s1_sof_reg    <= 1'b0;
            s1_last_reg   <= 1'b0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_sof_reg   <= 1'b0;
            out_last_reg  <= 1'b0;
        end else begin
            if (out_ready) begin
                out_valid_reg <= s1_valid_reg;
                out_sof_reg   <= s1_valid_reg && s1_sof_reg;
                out_last_reg  <= s1_valid_reg && s1_last_reg;
                if (s1_valid_reg) out_data_reg <= s1_data;
            end
            if (issue) begin
                s1_valid_reg <= 1'b1;
                s1_sof_reg   <= issue_sof;
                s1_last_reg  <= issue_last;
            end else if (out_ready) begin
                s1_valid_reg <= 1'b0;
            end
        end
    end

    assign o_tdata  = out_data_reg;
    assign o_tvalid = out_valid_reg;
    assign o_sof    = out_sof_reg;
    assign o_tlast  = out_last_reg;
    assign o_eof    = out_last_reg;
endmodule
